// File: rtl/rv_mem_stage.sv
// rv_mem_stage - RISC-V memory-access pipeline stage with MEM/WB register.
//
// Issues one data-memory bus access per load/store. The stage stalls the
// upstream pipeline until the bus reports ready. It builds byte strobes and
// lane-replicated store data, and it extracts and extends load data. It also
// registers the write-back triple (we, wa, wd) for the WB stage.
//
// Configuration macro: RV_MEM_MISALIGN_CHECK_EN
//   defined   : misaligned H/W accesses raise o_mem_misalign, the bus
//               request is suppressed and no register write occurs.
//   undefined : o_mem_misalign is tied low and the low address bits that are
//               irrelevant to the access size are ignored.
//
// Ports:
//   i_mem_clk, i_mem_rstn          clock, async active-low reset
//   i_mem_is_load, i_mem_dmem_we   load / store operation
//   i_mem_alu_res                  effective address or ALU result
//   i_mem_immext_res               extended immediate
//   i_mem_pc_plus_imm, _plus_4     PC-relative results
//   i_mem_dmem_wd                  store data (forwarded rs2)
//   i_mem_dmem_bytectrl            funct3 access size / signedness
//   i_mem_rf_we/_wa/_wd_pre_sel    register write controls, result select
//   o_mem_dmem_*                   data-memory bus request side
//   i_mem_dmem_rdata/_ready        data-memory bus response side
//   o_mem_stall                    freeze IF/ID/EX
//   o_mem_misalign                 misaligned-access flag
//   o_mem_rf_rd_mem                forwarding value to EX
//   o_mem_wb_rf_we/_wa/_wd         MEM/WB pipeline register

`ifndef XLEN
`define XLEN 32
`endif

module rv_mem_stage #(
    parameter int BW_DATA = `XLEN
) (
    input  logic               i_mem_clk,
    input  logic               i_mem_rstn,
    input  logic               i_mem_is_load,
    input  logic               i_mem_dmem_we,
    input  logic [BW_DATA-1:0] i_mem_alu_res,
    input  logic [BW_DATA-1:0] i_mem_immext_res,
    input  logic [BW_DATA-1:0] i_mem_pc_plus_imm,
    input  logic [BW_DATA-1:0] i_mem_pc_plus_4,
    input  logic [BW_DATA-1:0] i_mem_dmem_wd,
    input  logic [2:0]         i_mem_dmem_bytectrl,
    input  logic               i_mem_rf_we,
    input  logic [4:0]         i_mem_rf_wa,
    input  logic [1:0]         i_mem_rf_wd_pre_sel,
    output logic               o_mem_dmem_req,
    output logic               o_mem_dmem_wr,
    output logic [BW_DATA-1:0] o_mem_dmem_addr,
    output logic [3:0]         o_mem_dmem_wstrb,
    output logic [BW_DATA-1:0] o_mem_dmem_wdata,
    input  logic [BW_DATA-1:0] i_mem_dmem_rdata,
    input  logic               i_mem_dmem_ready,
    output logic               o_mem_stall,
    output logic               o_mem_misalign,
    output logic [BW_DATA-1:0] o_mem_rf_rd_mem,
    output logic               o_mem_wb_rf_we,
    output logic [4:0]         o_mem_wb_rf_wa,
    output logic [BW_DATA-1:0] o_mem_wb_rf_wd
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_access;
    logic               w_misalign;
    logic               w_req;
    logic               w_stall;
    logic [1:0]         w_off;
    logic               w_is_byte;
    logic               w_is_half;
    logic [7:0]         w_ld_byte;
    logic [15:0]        w_ld_half;
    logic [BW_DATA-1:0] w_ld_data;
    logic [BW_DATA-1:0] w_presel;

    assign w_access  = i_mem_is_load | i_mem_dmem_we;
    assign w_off     = i_mem_alu_res[1:0];
    assign w_is_byte = (i_mem_dmem_bytectrl[1:0] == 2'b00);
    assign w_is_half = (i_mem_dmem_bytectrl[1:0] == 2'b01);

`ifdef RV_MEM_MISALIGN_CHECK_EN
    // Only real memory ops are checked; funct3 of other ops is meaningless here.
    assign w_misalign = w_access &
                        ((w_is_half & w_off[0]) |
                         (~w_is_byte & ~w_is_half & (w_off != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req   = w_access & ~w_misalign;
    assign w_stall = w_req & ~i_mem_dmem_ready;

    assign o_mem_dmem_req  = w_req;
    assign o_mem_dmem_wr   = i_mem_dmem_we;
    assign o_mem_dmem_addr = {i_mem_alu_res[BW_DATA-1:2], 2'b00};
    assign o_mem_stall     = w_stall;
    assign o_mem_misalign  = w_misalign;

    // The state tracks an outstanding access. Stall is derived from req/ready
    // directly, so a zero-wait ready never leaves IDLE.
    always_ff @(posedge i_mem_clk or negedge i_mem_rstn) begin
        if (!i_mem_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req & ~i_mem_dmem_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_mem_dmem_ready)          w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // Store lane placement: strobes select lanes, data is replicated so that
    // every candidate lane already carries the right bytes.
    always_comb begin
        o_mem_dmem_wstrb = 4'b1111;
        o_mem_dmem_wdata = i_mem_dmem_wd;
        if (w_is_byte) begin
            o_mem_dmem_wstrb = 4'b0001 << w_off;
            o_mem_dmem_wdata = {(BW_DATA/8){i_mem_dmem_wd[7:0]}};
        end else if (w_is_half) begin
            o_mem_dmem_wstrb = 4'b0011 << {w_off[1], 1'b0};
            o_mem_dmem_wdata = {(BW_DATA/16){i_mem_dmem_wd[15:0]}};
        end
    end

    // Load extraction: bytectrl[2] marks the unsigned variants.
    always_comb begin
        w_ld_byte = i_mem_dmem_rdata[7:0];
        case (w_off)
            2'd1:    w_ld_byte = i_mem_dmem_rdata[15:8];
            2'd2:    w_ld_byte = i_mem_dmem_rdata[23:16];
            2'd3:    w_ld_byte = i_mem_dmem_rdata[31:24];
            default: w_ld_byte = i_mem_dmem_rdata[7:0];
        endcase
        w_ld_half = w_off[1] ? i_mem_dmem_rdata[31:16] : i_mem_dmem_rdata[15:0];
        w_ld_data = i_mem_dmem_rdata;
        if (w_is_byte) begin
            w_ld_data = {{(BW_DATA-8){w_ld_byte[7] & ~i_mem_dmem_bytectrl[2]}}, w_ld_byte};
        end else if (w_is_half) begin
            w_ld_data = {{(BW_DATA-16){w_ld_half[15] & ~i_mem_dmem_bytectrl[2]}}, w_ld_half};
        end
    end

    always_comb begin
        w_presel = i_mem_alu_res;
        case (i_mem_rf_wd_pre_sel)
            2'b01:   w_presel = i_mem_immext_res;
            2'b10:   w_presel = i_mem_pc_plus_imm;
            2'b11:   w_presel = i_mem_pc_plus_4;
            default: w_presel = i_mem_alu_res;
        endcase
    end

    assign o_mem_rf_rd_mem = w_presel;

    // A stalled cycle pushes a bubble; wa/wd hold since they are ignored.
    // Load data is captured only on the ready cycle, the first non-stall edge.
    always_ff @(posedge i_mem_clk or negedge i_mem_rstn) begin
        if (!i_mem_rstn) begin
            o_mem_wb_rf_we <= 1'b0;
            o_mem_wb_rf_wa <= '0;
            o_mem_wb_rf_wd <= '0;
        end else if (w_stall) begin
            o_mem_wb_rf_we <= 1'b0;
        end else begin
            o_mem_wb_rf_we <= i_mem_rf_we & ~w_misalign;
            o_mem_wb_rf_wa <= i_mem_rf_wa;
            o_mem_wb_rf_wd <= i_mem_is_load ? w_ld_data : w_presel;
        end
    end

endmodule

// File: tb/tb_rv_mem_stage.sv
// tb_rv_mem_stage - self-checking bench for rv_mem_stage.
//
// A behavioural model, written in terms of access size and byte offset
// arithmetic, predicts every output each cycle. Directed scenarios pin
// literal values for stores, loads with wait states, halfword lanes,
// misalignment and reset during a wait. Randomized transactions with random
// ready latency follow. Inputs are held stable while the stage stalls.
// Honours RV_MEM_MISALIGN_CHECK_EN the same way as the design.

module tb_rv_mem_stage;

`ifdef RV_MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        is_load, dmem_we, rf_we, ready;
    logic [31:0] alu, imm, pcimm, pc4, wd, rdata;
    logic [2:0]  bc;
    logic [4:0]  rf_wa;
    logic [1:0]  sel;
    logic        req, wr, stall, mis, wb_we;
    logic [31:0] addr, wdata, rd_mem, wb_wd;
    logic [3:0]  wstrb;
    logic [4:0]  wb_wa;

    // expected MEM/WB register contents
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    rv_mem_stage #(.BW_DATA(32)) dut (
        .i_mem_clk          (clk),
        .i_mem_rstn         (rstn),
        .i_mem_is_load      (is_load),
        .i_mem_dmem_we      (dmem_we),
        .i_mem_alu_res      (alu),
        .i_mem_immext_res   (imm),
        .i_mem_pc_plus_imm  (pcimm),
        .i_mem_pc_plus_4    (pc4),
        .i_mem_dmem_wd      (wd),
        .i_mem_dmem_bytectrl(bc),
        .i_mem_rf_we        (rf_we),
        .i_mem_rf_wa        (rf_wa),
        .i_mem_rf_wd_pre_sel(sel),
        .o_mem_dmem_req     (req),
        .o_mem_dmem_wr      (wr),
        .o_mem_dmem_addr    (addr),
        .o_mem_dmem_wstrb   (wstrb),
        .o_mem_dmem_wdata   (wdata),
        .i_mem_dmem_rdata   (rdata),
        .i_mem_dmem_ready   (ready),
        .o_mem_stall        (stall),
        .o_mem_misalign     (mis),
        .o_mem_rf_rd_mem    (rd_mem),
        .o_mem_wb_rf_we     (wb_we),
        .o_mem_wb_rf_wa     (wb_wa),
        .o_mem_wb_rf_wd     (wb_wd)
    );

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f);
        return 1 << (f % 4);
    endfunction

    function automatic int m_off(input logic [31:0] a, input logic [2:0] f);
        int sz;
        sz = m_size(f);
        return (sz == 4) ? 0 : int'(a % 4) / sz * sz;
    endfunction

    function automatic logic m_mis(input logic acc, input logic [31:0] a, input logic [2:0] f);
        return acc && MIS_EN && ((a % m_size(f)) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] f);
        longint unsigned v, mask;
        int sz;
        sz   = m_size(f);
        v    = 64'(rd >> (8 * m_off(a, f)));
        mask = (64'd1 << (8 * sz)) - 1;
        v    = v & mask;
        if (f < 4 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [2:0] f);
        int s;
        s = ((1 << m_size(f)) - 1) << m_off(a, f);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f);
        case (m_size(f))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_presel(input logic [1:0] s);
        case (s)
            2'd0:    return alu;
            2'd1:    return imm;
            2'd2:    return pcimm;
            default: return pc4;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic acc, m, e_req;
        acc   = is_load || dmem_we;
        m     = m_mis(acc, alu, bc);
        e_req = acc && !m;
        chk("req",      32'(req),    32'(e_req));
        chk("wr",       32'(wr),     32'(dmem_we));
        chk("addr",     addr,        alu & ~32'h3);
        chk("misalign", 32'(mis),    32'(m));
        chk("stall",    32'(stall),  32'(e_req && !ready));
        chk("rf_rd",    rd_mem,      m_presel(sel));
        chk("wb_we",    32'(wb_we),  32'(e_we));
        chk("wb_wa",    32'(wb_wa),  32'(e_wa));
        chk("wb_wd",    wb_wd,       e_wd);
        if (acc) begin
            chk("wstrb", 32'(wstrb), 32'(m_strb(alu, bc)));
            chk("wdata", wdata,      m_wdata(wd, bc));
        end
    endtask

    // one clock: compare at negedge, advance model at posedge, return at posedge+1
    task automatic step();
        logic acc, m, st, n_we;
        logic [4:0]  n_wa;
        logic [31:0] n_wd;
        @(negedge clk);
        compare();
        acc  = is_load || dmem_we;
        m    = m_mis(acc, alu, bc);
        st   = acc && !m && !ready;
        n_we = e_we; n_wa = e_wa; n_wd = e_wd;
        if (!rstn) begin
            n_we = 1'b0; n_wa = '0; n_wd = '0;
        end else if (st) begin
            n_we = 1'b0;
        end else begin
            n_we = rf_we && !m;
            n_wa = rf_wa;
            n_wd = is_load ? m_load(rdata, alu, bc) : m_presel(sel);
        end
        @(posedge clk);
        e_we = n_we; e_wa = n_wa; e_wd = n_wd;
        #1;
    endtask

    task automatic idle();
        is_load = 1'b0; dmem_we = 1'b0; rf_we = 1'b0; ready = 1'b0;
        alu = '0; imm = '0; pcimm = '0; pc4 = '0; wd = '0; rdata = '0;
        bc = 3'b010; rf_wa = '0; sel = '0;
    endtask

    initial begin
        logic [2:0] ld_codes [5];
        int lat;
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // reset
        idle();
        rstn = 1'b0;
        e_we = 1'b0; e_wa = '0; e_wd = '0;
        #2;
        chk("rst_wb_we", 32'(wb_we), 32'h0);
        chk("rst_wb_wd", wb_wd,      32'h0);
        step();
        step();
        rstn = 1'b1;
        step();

        // SW 0xDEADBEEF @0x100, zero-wait
        idle();
        dmem_we = 1'b1; bc = 3'b010; alu = 32'h100; wd = 32'hDEADBEEF; ready = 1'b1;
        #2;
        chk("sw_addr",  addr,         32'h100);
        chk("sw_wstrb", 32'(wstrb),   32'hF);
        chk("sw_wr",    32'(wr),      32'h1);
        chk("sw_stall", 32'(stall),   32'h0);
        chk("sw_wdata", wdata,        32'hDEADBEEF);
        step();

        // LB @0x103 with three wait cycles
        idle();
        is_load = 1'b1; bc = 3'b000; alu = 32'h103; rf_we = 1'b1; rf_wa = 5'd7;
        for (int i = 0; i < 3; i++) begin
            rdata = $urandom();
            #2;
            chk("lb_stall_wait", 32'(stall), 32'h1);
            step();
            chk("lb_no_wb_during_wait", 32'(wb_we), 32'h0);
        end
        ready = 1'b1; rdata = 32'h80112233;
        #2;
        chk("lb_stall_ready", 32'(stall), 32'h0);
        step();
        chk("lb_wb_wd", wb_wd,        32'hFFFFFF80);
        chk("lb_wb_we", 32'(wb_we),   32'h1);
        chk("lb_wb_wa", 32'(wb_wa),   32'd7);
        idle();
        step();
        chk("lb_wb_once", 32'(wb_we), 32'h0);

        // LHU @0x102
        idle();
        is_load = 1'b1; bc = 3'b101; alu = 32'h102; rf_we = 1'b1; rf_wa = 5'd3;
        ready = 1'b1; rdata = 32'h8001ABCD;
        step();
        chk("lhu_wb_wd", wb_wd, 32'h00008001);

        // SH 0x1234 @0x102
        idle();
        dmem_we = 1'b1; bc = 3'b001; alu = 32'h102; wd = 32'hFFFF1234; ready = 1'b1;
        #2;
        chk("sh_wstrb", 32'(wstrb), 32'hC);
        chk("sh_wdata", wdata,      32'h12341234);
        step();

        // LW @0x101
        idle();
        is_load = 1'b1; bc = 3'b010; alu = 32'h101; rf_we = 1'b1; rf_wa = 5'd9;
        ready = 1'b1; rdata = 32'hCAFEF00D;
        #2;
        chk("lw_mis_addr", addr,        32'h100);
        chk("lw_mis_flag", 32'(mis),    32'(MIS_EN));
        chk("lw_mis_req",  32'(req),    32'(!MIS_EN));
        step();
        chk("lw_mis_wb_we", 32'(wb_we), 32'(!MIS_EN));

        // reset asserted during WAIT
        idle();
        is_load = 1'b1; bc = 3'b010; alu = 32'h200; rf_we = 1'b1; rf_wa = 5'd4;
        step();
        step();
        rstn = 1'b0;
        idle();
        e_we = 1'b0; e_wa = '0; e_wd = '0;
        #1;
        chk("rstwait_req",   32'(req),   32'h0);
        chk("rstwait_wb_we", 32'(wb_we), 32'h0);
        step();
        rstn = 1'b1;
        step();
        chk("rstwait_after", 32'(wb_we), 32'h0);
        // a fresh zero-wait access must not stall
        is_load = 1'b1; alu = 32'h204; rf_we = 1'b1; rf_wa = 5'd5; ready = 1'b1;
        #2;
        chk("rstwait_fresh_stall", 32'(stall), 32'h0);
        step();

        // randomized traffic
        for (int t = 0; t < 400; t++) begin
            int kind;
            idle();
            kind    = $urandom_range(0, 2);
            is_load = (kind == 1);
            dmem_we = (kind == 2);
            bc      = (kind == 2) ? ld_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
            alu     = $urandom();
            imm     = $urandom();
            pcimm   = $urandom();
            pc4     = $urandom();
            wd      = $urandom();
            sel     = 2'($urandom_range(0, 3));
            rf_we   = (kind != 2) ? 1'($urandom_range(0, 1) | is_load) : 1'b0;
            rf_wa   = 5'($urandom_range(0, 31));
            lat     = $urandom_range(0, 3);
            if ((is_load || dmem_we) && !m_mis(1'b1, alu, bc)) begin
                for (int i = 0; i < lat; i++) begin
                    ready = 1'b0;
                    rdata = $urandom();
                    step();
                end
                ready = 1'b1;
                rdata = $urandom();
                step();
            end else begin
                ready = 1'($urandom_range(0, 1));
                rdata = $urandom();
                step();
            end
        end

        idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
